sprite_row_fetch: RTL
=====================

// Module: sprite_row_fetch
// PURPOSE
// - Address generator and consumer for the synchronous sprite ROM (1-cycle read latency, word = one pixel).
// - On each line_start, fetches one sprite row from ROM into a local line buffer. During active video it
//   answers per-pixel queries with colour and hit.
// - Sits between the VGA timing counters and the pixel mux (puck/paddle sprites).
// PARAMETERS
// - DATA_WIDTH    12   ROM word / pixel colour width (RGB444)
// - ADDRESS_WIDTH 12   ROM address width
// - SPRITE_W      32   sprite width in pixels (ROM words per row)
// - SPRITE_H      32   sprite height in rows
// - COORD_W       10   screen coordinate width
// - TRANSPARENT   0    colour code treated as no-hit
// PORTS
// - clk          in   1              system clock
// - reset        in   1              asynchronous, active-high
// - line_start   in   1              1-cycle pulse at start of hblank; line_y is valid with it
// - line_y       in   COORD_W        screen row about to be displayed
// - sprite_x     in   COORD_W        sprite left edge; sampled at line_start
// - sprite_y     in   COORD_W        sprite top edge; sampled at line_start
// - rom_addr     out  ADDRESS_WIDTH  ROM read address
// - rom_data     in   DATA_WIDTH     ROM data, valid one cycle after rom_addr
// - pix_x        in   COORD_W        current pixel column query
// - pix_color    out  DATA_WIDTH     buffered colour for pix_x, registered
// - pix_hit      out  1              1 = opaque sprite pixel at pix_x, registered
// - busy         out  1              fetch in progress
// BEHAVIOUR
// - Reset: state=IDLE; rom_addr=0, pix_color=0, pix_hit=0, busy=0; row_valid=0; buffer contents don't-care.
// - States: IDLE -> CHECK -> FETCH -> LAST -> IDLE.
// - IDLE: on line_start, latch line_y, sprite_x, sprite_y; go to CHECK.
// - CHECK:
//   - row = line_y - sprite_y, COORD_W-bit wrap.
//   - If row < SPRITE_H: row_valid=0, col=0, go to FETCH.
//   - Else: row_valid=0, go to IDLE.
// - FETCH:
//   - Each cycle: rom_addr = row*SPRITE_W + col, truncated to ADDRESS_WIDTH; col++.
//   - rom_data seen in cycle k is written to buffer[col_issued_in_k-1] (one-cycle delayed write index/enable).
//   - After col = SPRITE_W-1 is issued, go to LAST.
// - LAST: write final word; set row_valid=1; go to IDLE.
// - Fetch latency: line_start to row_valid = SPRITE_W+2 cycles. busy=1 in CHECK/FETCH/LAST.
// - line_start while busy: abort. Latch new inputs, row_valid=0, go to CHECK. No partial row is ever shown.
// - Query, 1-cycle latency: dx = pix_x - sprite_x_latched.
//   - Next cycle: pix_hit = row_valid & (dx < SPRITE_W) & (buf[dx] != TRANSPARENT); pix_color = buf[dx].
//   - When no hit, pix_color = 0.
// - Boundaries:
//   - pix_x < sprite_x: unsigned wrap gives dx >= SPRITE_W, so no hit.
//   - Last sprite row (row = SPRITE_H-1) fetched; row = SPRITE_H gives no fetch.
//   - rom_addr holds its last value when idle.
// - Reset mid-fetch returns to reset state immediately.
// CONFIGURATION
// - SPRITE_MIRROR_EN defined:
//   - Adds input port mirror (1 bit), sampled at line_start.
//   - When 1, the buffer write index = SPRITE_W-1-col. Sprite is drawn horizontally flipped; query path unchanged.
// - Undefined: no mirror port; write index = col.
// STRUCTURE
// - Shared package/header airhockey_gfx_pkg holds:
//   - FSM state encodings
//   - RGB444 width
//   - TRANSPARENT default
//   - sprite dimension constants
// - One sub-module, sprite_line_buf: SPRITE_W x DATA_WIDTH, 1 write port, 1 registered read port.
//   It provides the query's 1-cycle latency.
// TESTING
// - Bench pairs the block with a ROM model preloaded rom[i] = i+1 (SPRITE_W=SPRITE_H=32).
// - Scenario 1: line_start with line_y=105, sprite_y=100.
//   - rom_addr steps 160..191 on consecutive cycles.
//   - busy high 34 cycles; row_valid after 34.
// - Scenario 2: after scenario 1, sprite_x=200; pix_x=200 then 231 then 232.
//   - pix_hit=1 with pix_color=161, then 1 with pix_color=192, then 0.
// - Scenario 3: line_y=99 or 132 with sprite_y=100.
//   - No rom_addr activity; busy high 1 cycle; pix_hit stays 0.
// - Scenario 4: second line_start 10 cycles into a fetch.
//   - Fetch restarts at the new row's base address.
//   - pix_hit=0 until the full new row is loaded.
// - Scenario 5: rom word = TRANSPARENT at column 5; query dx=5 -> pix_hit=0, pix_color=0.
// - Scenario 6: reset asserted mid-FETCH -> all outputs 0 asynchronously.
// - With SPRITE_MIRROR_EN and mirror=1: dx=0 returns the last word of the row.

Source files
------------

// File: rtl/airhockey_gfx_pkg.sv
// Shared graphics constants and the sprite row fetch FSM encoding.
package airhockey_gfx_pkg;

  localparam int unsigned RGB444_W            = 12;
  localparam int unsigned TRANSPARENT_DEFAULT = 0;
  localparam int unsigned SPRITE_W_DEFAULT    = 32;
  localparam int unsigned SPRITE_H_DEFAULT    = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StFetch = 2'd2,
    StLast  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/sprite_line_buf.sv
// One-row sprite line buffer: single write port, registered read port.
module sprite_line_buf
  import airhockey_gfx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RGB444_W,
  parameter int unsigned DEPTH      = SPRITE_W_DEFAULT,
  parameter int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are don't-care after reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sprite_row_fetch.sv
// Fetches one sprite row from the synchronous ROM per line and answers per-pixel hit queries.
// Optional SPRITE_MIRROR_EN adds a mirror input that flips the row horizontally.
module sprite_row_fetch
  import airhockey_gfx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = RGB444_W,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned SPRITE_W      = SPRITE_W_DEFAULT,
  parameter int unsigned SPRITE_H      = SPRITE_H_DEFAULT,
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned TRANSPARENT   = TRANSPARENT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     line_start,
  input  logic [COORD_W-1:0]       line_y,
  input  logic [COORD_W-1:0]       sprite_x,
  input  logic [COORD_W-1:0]       sprite_y,
`ifdef SPRITE_MIRROR_EN
  input  logic                     mirror,
`endif
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  input  logic [COORD_W-1:0]       pix_x,
  output logic [DATA_WIDTH-1:0]    pix_color,
  output logic                     pix_hit,
  output logic                     busy
);

  localparam int unsigned               ColW      = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam logic [ColW-1:0]           ColLast   = ColW'(SPRITE_W - 1);
  localparam logic [COORD_W-1:0]        SpriteWc  = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0]        SpriteHc  = COORD_W'(SPRITE_H);
  localparam logic [ADDRESS_WIDTH-1:0]  RowStride = ADDRESS_WIDTH'(SPRITE_W);
  localparam logic [DATA_WIDTH-1:0]     TranspC   = DATA_WIDTH'(TRANSPARENT);

  fetch_state_e             state_q, state_d;
  logic [COORD_W-1:0]       line_y_q, sprite_x_q, sprite_y_q;
  logic [ColW-1:0]          col_q, col_d;
  logic [ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                     row_valid_q, row_valid_d;
  logic                     wr_en_q, wr_en_d;
  logic [ColW-1:0]          wr_idx_q, wr_idx_d;
  logic                     hit_q;

  logic [COORD_W-1:0]       row, dx;
  logic [ADDRESS_WIDTH-1:0] row_base;
  logic [ColW-1:0]          issue_idx;
  logic [DATA_WIDTH-1:0]    buf_rdata;

  assign row      = line_y_q - sprite_y_q;
  assign dx       = pix_x - sprite_x_q;
  assign row_base = ADDRESS_WIDTH'(row) * RowStride;

`ifdef SPRITE_MIRROR_EN
  logic mirror_q;
  assign issue_idx = mirror_q ? (ColLast - col_q) : col_q;
`else
  assign issue_idx = col_q;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rom_addr_d  = rom_addr_q;
    row_valid_d = row_valid_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    if (line_start) begin
      // A new line always restarts; an interrupted row must never be shown.
      state_d = StCheck;
      if (state_q != StIdle) begin
        row_valid_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StCheck: begin
          row_valid_d = 1'b0;
          if (row < SpriteHc) begin
            col_d      = '0;
            rom_addr_d = row_base;
            state_d    = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
        StFetch: begin
          // ROM data for this column arrives next cycle, so the write is delayed by one.
          wr_en_d  = 1'b1;
          wr_idx_d = issue_idx;
          if (col_q == ColLast) begin
            state_d = StLast;
          end else begin
            col_d      = col_q + 1'b1;
            rom_addr_d = row_base + ADDRESS_WIDTH'(col_d);
          end
        end
        StLast: begin
          row_valid_d = 1'b1;
          state_d     = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      line_y_q    <= '0;
      sprite_x_q  <= '0;
      sprite_y_q  <= '0;
      col_q       <= '0;
      rom_addr_q  <= '0;
      row_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      hit_q       <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      mirror_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      rom_addr_q  <= rom_addr_d;
      row_valid_q <= row_valid_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      hit_q       <= row_valid_q & (dx < SpriteWc);
      if (line_start) begin
        line_y_q   <= line_y;
        sprite_x_q <= sprite_x;
        sprite_y_q <= sprite_y;
`ifdef SPRITE_MIRROR_EN
        mirror_q   <= mirror;
`endif
      end
    end
  end

  sprite_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (SPRITE_W),
    .IDX_W     (ColW)
  ) u_line_buf (
    .clk  (clk),
    .reset(reset),
    .we   (wr_en_q),
    .waddr(wr_idx_q),
    .wdata(rom_data),
    .raddr(dx[ColW-1:0]),
    .rdata(buf_rdata)
  );

  always_comb begin
    pix_hit   = hit_q & (buf_rdata != TranspC);
    pix_color = pix_hit ? buf_rdata : '0;
  end

  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != StIdle);

endmodule
